// File: rtl/matrix_mult_pkg.sv
// Shared types, default widths and helpers for the matrix_mult datapath.
package matrix_mult_pkg;

  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } div_state_e;

  // Magnitude of a sign-extended operand; the extra bit keeps |most negative| exact.
  function automatic logic [32:0] abs_ext(input logic signed [31:0] x);
    logic signed [32:0] xe;
    xe = {x[31], x};
    abs_ext = xe[32] ? -xe : xe;
  endfunction

endpackage

// File: rtl/matrix_mult_sdiv_step.sv
// One restoring division step: shift in a dividend bit, compare, conditionally subtract.
module matrix_mult_sdiv_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] part_in,
  input  logic          bit_in,
  input  logic [VW:0]   dvs_mag,
  output logic [VW-1:0] part_out,
  output logic          q_bit
);

  logic [VW:0] shifted;

  // part_in < |divisor| <= 2^(VW-1), so the shifted value and the result both fit.
  always_comb begin
    shifted  = {part_in, bit_in};
    q_bit    = (shifted >= dvs_mag);
    part_out = q_bit ? VW'(shifted - dvs_mag) : shifted[VW-1:0];
  end

endmodule

// File: rtl/matrix_mult_sdiv_16s_8s_seq.sv
// Radix-2 sequential signed divider with C semantics (truncate toward zero,
// remainder follows dividend sign); valid/ready on both sides, one op in flight.
module matrix_mult_sdiv_16s_8s_seq
  import matrix_mult_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIV_DIVISOR_W
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero,
  output logic                             overflow
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int PW = VW + 1;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] DVD_MIN = {1'b1, {(DW-1){1'b0}}};

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
  logic [DW-1:0] acc_q, acc_d;
  logic [VW-1:0] part_q, part_d;
  logic [PW-1:0] dvs_q, dvs_d;
  logic          qsign_q, qsign_d;
  logic          rsign_q, rsign_d;
  logic [VW-1:0] dvd_lo_q, dvd_lo_d;
  logic          dbz_lat_q, dbz_lat_d;
  logic          ovf_lat_q, ovf_lat_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [VW-1:0] step_part;
  logic          step_bit;

  matrix_mult_sdiv_step #(.VW(VW)) u_step (
    .part_in (part_q),
    .bit_in  (acc_q[DW-1]),
    .dvs_mag (dvs_q),
    .part_out(step_part),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    part_d    = part_q;
    dvs_d     = dvs_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    dvd_lo_d  = dvd_lo_q;
    dbz_lat_d = dbz_lat_q;
    ovf_lat_d = ovf_lat_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d     = DW'(abs_ext(32'(dividend)));
          dvs_d     = PW'(abs_ext(32'(divisor)));
          qsign_d   = dividend[DW-1] ^ divisor[VW-1];
          rsign_d   = dividend[DW-1];
          dvd_lo_d  = dividend[VW-1:0];
          dbz_lat_d = (divisor == '0);
          ovf_lat_d = (dividend == DVD_MIN) && (divisor == '1);
          part_d    = '0;
          cnt_d     = CW'(DW - 1);
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d  = {acc_q[DW-2:0], step_bit};
        part_d = step_part;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (dbz_lat_q) begin
          quo_d = '1;
          rem_d = dvd_lo_q;
        end else begin
          quo_d = qsign_q ? -acc_q : acc_q;
          rem_d = rsign_q ? -part_q : part_q;
        end
        dbz_d   = dbz_lat_q;
        ovf_d   = ovf_lat_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      part_q      <= '0;
      dvs_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      dvd_lo_q    <= '0;
      dbz_lat_q   <= 1'b0;
      ovf_lat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      part_q      <= part_d;
      dvs_q       <= dvs_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      dvd_lo_q    <= dvd_lo_d;
      dbz_lat_q   <= dbz_lat_d;
      ovf_lat_q   <= ovf_lat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_matrix_mult_sdiv_16s_8s_seq.sv
// Directed and random-stream bench for the sequential signed divider.
`timescale 1ns/1ps
module tb_matrix_mult_sdiv_16s_8s_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] dividend = '0;
  logic signed [7:0]  divisor = '0;
  logic               in_ready, out_valid, div_by_zero, overflow;
  logic signed [15:0] quotient;
  logic signed [7:0]  remainder;

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  matrix_mult_sdiv_16s_8s_seq dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  // C-semantics reference built on the language's own truncating / and %.
  function automatic void ref_div(input logic signed [15:0] a, input logic signed [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 16'hFFFF; r = a[7:0]; dz = 1'b1; ov = 1'b0;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[15:0]; r = ri[7:0]; dz = 1'b0;
      ov = (ai == -32768) && (bi == -1);
    end
  endfunction

  // Caller is at a negedge; drives one op, waits for the result, takes it.
  task automatic do_op(input logic signed [15:0] a, input logic signed [7:0] b,
                       output logic signed [15:0] q, output logic signed [7:0] r,
                       output logic dz, output logic ov, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge ap_clk); t++; end
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge ap_clk);
    in_valid = 1'b0; dividend = ~a; divisor = ~b;
    lat = 0;
    while (!out_valid && lat < 64) begin @(negedge ap_clk); lat++; end
    q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0b ov=%0b lat=%0d", a, b, q, r, dz, ov, lat);
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b1;
    #2 ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (quotient !== 16'sd0 || remainder !== 8'sd0) begin
      errors++; $display("FAIL reset_data: got q=%0d r=%0d want 0 0", quotient, remainder);
    end
    checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got dz=%b ov=%b want 0 0", div_by_zero, overflow);
    end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic test_signs();
    int at[4] = '{100, -100, 100, -100};
    int bt[4] = '{7, 7, -7, -7};
    int qt[4] = '{14, -14, -14, 14};
    int rt[4] = '{2, -2, 2, -2};
    logic signed [15:0] q; logic signed [7:0] r; logic dz, ov; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(16'(at[i]), 8'(bt[i]), q, r, dz, ov, lat);
      checks++; if (q !== 16'(qt[i]) || r !== 8'(rt[i])) begin
        errors++; $display("FAIL signs_%0d: got q=%0d r=%0d want q=%0d r=%0d", i, q, r, qt[i], rt[i]);
      end
      checks++; if (lat != 17) begin errors++; $display("FAIL signs_latency_%0d: got %0d want 17", i, lat); end
    end
  endtask

  task automatic test_inverse();
    logic signed [15:0] q; logic signed [7:0] r; logic dz, ov; int lat;
    int a, d, prod, qi, ri;
    do_op(-16'sd16256, -8'sd128, q, r, dz, ov, lat);
    checks++; if (q !== 16'sd127 || r !== 8'sd0) begin
      errors++; $display("FAIL inv_m16256: got q=%0d r=%0d want 127 0", q, r);
    end
    do_op(16'sd16129, 8'sd127, q, r, dz, ov, lat);
    checks++; if (q !== 16'sd127 || r !== 8'sd0) begin
      errors++; $display("FAIL inv_16129: got q=%0d r=%0d want 127 0", q, r);
    end
    for (int ia = 0; ia < 16; ia++) begin
      for (int id = 0; id < 16; id++) begin
        a = -128 + 17 * ia;
        d = -128 + 17 * id;
        prod = a * d;
        do_op(16'(prod), 8'(d), q, r, dz, ov, lat);
        qi = q; ri = r;
        checks++; if (qi * d + ri != prod || qi != a || ri != 0) begin
          errors++; $display("FAIL sweep_%0dx%0d: got q=%0d r=%0d want q=%0d r=0", a, d, qi, ri, a);
        end
      end
    end
  endtask

  task automatic test_corners();
    int at[6]  = '{-32768, -32768, 5, -32768, 32767, -1};
    int bt[6]  = '{-1, -128, 0, 0, -128, 5};
    int qt[6]  = '{-32768, 256, -1, -1, -255, 0};
    int rt[6]  = '{0, 0, 5, 0, 127, -1};
    bit dzt[6] = '{0, 0, 1, 1, 0, 0};
    bit ovt[6] = '{1, 0, 0, 0, 0, 0};
    logic signed [15:0] q; logic signed [7:0] r; logic dz, ov; int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(16'(at[i]), 8'(bt[i]), q, r, dz, ov, lat);
      checks++; if (q !== 16'(qt[i]) || r !== 8'(rt[i]) || dz !== dzt[i] || ov !== ovt[i]) begin
        errors++;
        $display("FAIL corner_%0d_%0d: got q=%0d r=%0d dz=%b ov=%b want q=%0d r=%0d dz=%0d ov=%0d",
                 at[i], bt[i], q, r, dz, ov, qt[i], rt[i], dzt[i], ovt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] q; logic signed [7:0] r; logic dz, ov; int lat;
    in_valid = 1'b1; dividend = 16'sd12345; divisor = -8'sd99;
    @(negedge ap_clk);
    in_valid = 1'b0; dividend = 16'sd1; divisor = 8'sd1;
    lat = 0;
    while (!out_valid && lat < 64) begin @(negedge ap_clk); lat++; end
    checks++; if (lat != 17) begin errors++; $display("FAIL bp_latency: got %0d want 17", lat); end
    for (int c = 0; c < 20; c++) begin
      @(negedge ap_clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== -16'sd124 || remainder !== 8'sd69 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=-124 r=69",
                 c, out_valid, in_ready, quotient, remainder);
      end
    end
    $display("op 12345 / -99 -> q=%0d r=%0d held 20 cycles", quotient, remainder);
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    do_op(-16'sd7, 8'sd2, q, r, dz, ov, lat);
    checks++; if (q !== -16'sd3 || r !== -8'sd1 || lat != 17) begin
      errors++; $display("FAIL bp_next: got q=%0d r=%0d lat=%0d want q=-3 r=-1 lat=17", q, r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] q; logic signed [7:0] r; logic dz, ov; int lat;
    in_valid = 1'b1; dividend = 16'sd30000; divisor = 8'sd7;
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (7) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'sd0 || remainder !== 8'sd0 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL midreset_%0d: got v=%b rdy=%b q=%0d r=%0d dz=%b ov=%b want 0 1 0 0 0 0",
                 k, out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
      end
      @(negedge ap_clk);
    end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    do_op(16'sd1000, 8'sd3, q, r, dz, ov, lat);
    checks++; if (q !== 16'sd333 || r !== 8'sd1 || lat != 17) begin
      errors++; $display("FAIL midreset_next: got q=%0d r=%0d lat=%0d want q=333 r=1 lat=17", q, r, lat);
    end
  endtask

  task automatic test_random();
    int n;
    int got;
    n = 1000;
    got = 0;
    fork
      begin : drv
        for (int i = 0; i < n; i++) begin
          logic signed [15:0] a;
          logic signed [7:0]  b;
          logic [15:0] eq; logic [7:0] er; logic edz, eov;
          exp_t e;
          int t;
          a = 16'($urandom);
          b = 8'($urandom);
          case ($urandom_range(0, 15))
            0: b = 8'sd0;
            1: begin a = -16'sd32768; b = -8'sd1; end
            2: a = -16'sd32768;
            3: b = -8'sd128;
            default: ;
          endcase
          repeat ($urandom_range(0, 3)) @(negedge ap_clk);
          in_valid = 1'b1; dividend = a; divisor = b;
          t = 0;
          while (!in_ready && t < 200) begin @(negedge ap_clk); t++; end
          if (t >= 200) begin
            checks++; errors++; $display("FAIL rand_accept_timeout: op %0d got no in_ready", i);
          end
          ref_div(a, b, eq, er, edz, eov);
          e.a = a; e.b = b; e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
          exp_q.push_back(e);
          @(negedge ap_clk);
          in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
        end
      end
      begin : mon
        int cyc;
        cyc = 0;
        while (got < n && cyc < n * 60) begin
          @(negedge ap_clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL rand_extra: got unexpected q=%0d r=%0d", quotient, remainder);
            end else begin
              e = exp_q.pop_front();
              if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || overflow !== e.ov) begin
                errors++;
                $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d dz=%b ov=%b want q=%0d r=%0d dz=%b ov=%b",
                         got, $signed(e.a), $signed(e.b), quotient, remainder, div_by_zero, overflow,
                         $signed(e.q), $signed(e.r), e.dz, e.ov);
              end else begin
                $display("rand %0d: %0d / %0d -> q=%0d r=%0d dz=%b ov=%b", got, $signed(e.a),
                         $signed(e.b), quotient, remainder, div_by_zero, overflow);
              end
            end
            got++;
          end
        end
        out_ready = 1'b0;
        checks++; if (got < n) begin errors++; $display("FAIL rand_count: got %0d results want %0d", got, n); end
      end
    join
    @(negedge ap_clk);
    out_ready = 1'b1;
    begin
      int extra;
      extra = 0;
      repeat (30) begin @(negedge ap_clk); if (out_valid) extra++; end
      out_ready = 1'b0;
      checks++; if (extra != 0 || exp_q.size() != 0) begin
        errors++; $display("FAIL rand_leftover: got extra=%0d pending=%0d want 0 0", extra, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_inverse();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
